line_rasterizer: RTL



---
 rtl/gpu_pkg.sv | 47 ++++
 rtl/line_rasterizer_if.sv | 28 ++
 rtl/line_setup.sv | 29 ++
 rtl/line_rasterizer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types and constants for the line rasterizer: coordinate widths,
// splitter field offsets, FSM encoding and the point type.
package gpu_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 16;
    localparam int LOC_W   = 38;

    // Bit offsets of {x0, y0, x1, y1} inside the splitter's locations word
    localparam int LOC_X0_LSB = 28;
    localparam int LOC_Y0_LSB = 19;
    localparam int LOC_X1_LSB = 9;
    localparam int LOC_Y1_LSB = 0;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int DX_W  = 11;
    localparam int ERR_W = 12;
    localparam int E2_W  = 13;

    localparam logic [X_W-1:0]          X_ONE    = 10'd1;
    localparam logic [Y_W-1:0]          Y_ONE    = 9'd1;
    localparam logic signed [ERR_W-1:0] ERR_ZERO = 12'sd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } raster_state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } point_t;

    function automatic point_t loc_point(input logic [LOC_W-1:0] loc,
                                         input int x_lsb, input int y_lsb);
        point_t p;
        p.x = loc[x_lsb +: X_W];
        p.y = loc[y_lsb +: Y_W];
        return p;
    endfunction

endpackage

// File: rtl/line_rasterizer_if.sv
// Splitter-side primitive handshake and framebuffer-side pixel stream of the
// line rasterizer; slave is the rasterizer's view, master the environment's.
interface line_rasterizer_if;
    import gpu_pkg::*;

    logic [LOC_W-1:0]   locations;
    logic [COLOR_W-1:0] color;
    logic               loc_valid;
    logic               loc_ready;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [COLOR_W-1:0] pix_color;
    logic               pix_valid;
    logic               pix_ready;
    logic               busy;
    logic               done;

    modport slave (
        input  locations, color, loc_valid, pix_ready,
        output loc_ready, pix_x, pix_y, pix_color, pix_valid, busy, done
    );

    modport master (
        output locations, color, loc_valid, pix_ready,
        input  loc_ready, pix_x, pix_y, pix_color, pix_valid, busy, done
    );

endinterface

// File: rtl/line_setup.sv
// Combinational Bresenham setup: deltas, step directions and initial error
// for one line; the rasterizer registers these during its SETUP cycle.
module line_setup
    import gpu_pkg::*;
(
    input  point_t                  p0,
    input  point_t                  p1,
    output logic signed [DX_W-1:0]  dx,
    output logic signed [DX_W-1:0]  dy,
    output logic                    sx_neg,
    output logic                    sy_neg,
    output logic signed [ERR_W-1:0] err0
);

    logic [X_W-1:0] xdiff_s;
    logic [Y_W-1:0] ydiff_s;

    // Direction is negative unless the coordinate strictly increases
    always_comb begin
        sx_neg  = !(p0.x < p1.x);
        sy_neg  = !(p0.y < p1.y);
        xdiff_s = sx_neg ? (p0.x - p1.x) : (p1.x - p0.x);
        ydiff_s = sy_neg ? (p0.y - p1.y) : (p1.y - p0.y);
        dx      = $signed({1'b0, xdiff_s});
        dy      = -$signed({2'b00, ydiff_s});
        err0    = ERR_W'(dx) + ERR_W'(dy);
    end

endmodule

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: one primitive in, one pixel beat per accepted
// cycle out. Define LINE_RASTER_CLIP_EN to drop pixels outside the screen.
module line_rasterizer
    import gpu_pkg::*;
(
    input  logic            clk,
    input  logic            n_rst,
    line_rasterizer_if.slave bus
);

    raster_state_t           state_q, state_d;
    point_t                  p0_q, p0_d, p1_q, p1_d;
    logic [COLOR_W-1:0]      color_q, color_d;
    logic [X_W-1:0]          x_q, x_d;
    logic [Y_W-1:0]          y_q, y_d;
    logic signed [DX_W-1:0]  dx_q, dx_d, dy_q, dy_d;
    logic                    sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic signed [ERR_W-1:0] err_q, err_d;

    logic signed [DX_W-1:0]  su_dx_s, su_dy_s;
    logic                    su_sx_neg_s, su_sy_neg_s;
    logic signed [ERR_W-1:0] su_err0_s;
    logic signed [E2_W-1:0]  e2_s;
    logic                    step_x_s, step_y_s, at_end_s, in_bounds_s, advance_s;

    line_setup u_setup (
        .p0     (p0_q),
        .p1     (p1_q),
        .dx     (su_dx_s),
        .dy     (su_dy_s),
        .sx_neg (su_sx_neg_s),
        .sy_neg (su_sy_neg_s),
        .err0   (su_err0_s)
    );

`ifdef LINE_RASTER_CLIP_EN
    // Off-screen pixels are skipped without waiting on the consumer
    always_comb begin
        in_bounds_s = (x_q < X_W'(SCREEN_W)) && (y_q < Y_W'(SCREEN_H));
    end
`else
    // Without clipping every pixel is in bounds
    always_comb begin
        in_bounds_s = 1'b1;
    end
`endif

    // Step decision from the pre-update error term
    always_comb begin
        at_end_s  = (x_q == p1_q.x) && (y_q == p1_q.y);
        advance_s = (state_q == DRAW) && (bus.pix_ready || !in_bounds_s);
        e2_s      = $signed({err_q, 1'b0});
        step_x_s  = (e2_s >= E2_W'(dy_q));
        step_y_s  = (e2_s <= E2_W'(dx_q));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.loc_valid) state_d = SETUP;
                else               state_d = IDLE;
            end
            SETUP: state_d = DRAW;
            DRAW: begin
                if (advance_s && at_end_s) state_d = DONE;
                else                       state_d = DRAW;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch primitive, load setup terms, Bresenham stepping
    always_comb begin
        p0_d     = p0_q;
        p1_d     = p1_q;
        color_d  = color_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (bus.loc_valid) begin
                    p0_d    = loc_point(bus.locations, LOC_X0_LSB, LOC_Y0_LSB);
                    p1_d    = loc_point(bus.locations, LOC_X1_LSB, LOC_Y1_LSB);
                    color_d = bus.color;
                end else begin
                    p0_d    = p0_q;
                end
            end
            SETUP: begin
                dx_d     = su_dx_s;
                dy_d     = su_dy_s;
                sx_neg_d = su_sx_neg_s;
                sy_neg_d = su_sy_neg_s;
                err_d    = su_err0_s;
                x_d      = p0_q.x;
                y_d      = p0_q.y;
            end
            DRAW: begin
                if (advance_s && !at_end_s) begin
                    if (step_x_s) x_d = sx_neg_q ? (x_q - X_ONE) : (x_q + X_ONE);
                    else          x_d = x_q;
                    if (step_y_s) y_d = sy_neg_q ? (y_q - Y_ONE) : (y_q + Y_ONE);
                    else          y_d = y_q;
                    err_d = err_q + (step_x_s ? ERR_W'(dy_q) : ERR_ZERO)
                                  + (step_y_s ? ERR_W'(dx_q) : ERR_ZERO);
                end else begin
                    err_d = err_q;
                end
            end
            default: err_d = err_q;
        endcase
    end

    // Outputs decoded from registered state and datapath
    always_comb begin
        bus.loc_ready = (state_q == IDLE);
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == DONE);
        bus.pix_valid = (state_q == DRAW) && in_bounds_s;
        bus.pix_x     = x_q;
        bus.pix_y     = y_q;
        bus.pix_color = color_q;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            p0_q     <= '0;
            p1_q     <= '0;
            color_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            color_q  <= color_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            err_q    <= err_d;
        end
    end

endmodule
